sll_iter: RTL and testbench

//  Multi-cycle shift-left-logical unit for the ALU shift path (SLL/SLLV). It is the left-direction

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/sll_step.sv | 15 +
 rtl/sll_iter.sv | 121 ++++++++++++
 tb/tb_sll_iter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word and shift-amount widths, the shift-unit
// FSM state type used by both left- and right-shift units, and a per-cycle
// step-size helper.
package cpu_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  // Bits to shift this cycle: min(step, count). The result is one bit wider than
  // count so that a step of 32 can still be represented.
  function automatic logic [SHAMT_W:0] step_amt(input logic [SHAMT_W-1:0] count,
                                                input int unsigned step);
    logic [SHAMT_W:0] cnt_ext;
    cnt_ext = {1'b0, count};
    if (32'(cnt_ext) < step) begin
      return cnt_ext;
    end
    return step[SHAMT_W:0];
  endfunction

endpackage

// File: rtl/sll_step.sv
// Combinational 64-bit logical left shift by n (0..32); zeros fill from bit 0.
module sll_step
  import cpu_pkg::*;
(
  input  logic [2*WORD_W-1:0] w,
  input  logic [SHAMT_W:0]    n,
  output logic [2*WORD_W-1:0] y
);

  // Single barrel stage, used once per cycle by the iterative shifter.
  always_comb begin
    y = w << n;
  end

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle shift-left-logical unit (SLL/SLLV) with valid/ready handshakes.
// The result is {hi_out, lo_out} = {32'h0, a} << amt, where hi_out collects the
// bits shifted out of bit 31 for 64-bit concatenation.
// Optional build macro: SLL_EARLY_EXIT_EN -- leave SHIFT as soon as the working
// register is all-zero.
module sll_iter
  import cpu_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              v,
  input  logic [4:0]        sa,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] lo_out,
  output logic [WORD_W-1:0] hi_out
);

  shift_state_t         state_q;
  logic [2*WORD_W-1:0]  w_q;
  logic [SHAMT_W-1:0]   count_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [SHAMT_W-1:0]   amt;
  logic [SHAMT_W:0]     step_n;
  logic [SHAMT_W-1:0]   count_next;
  logic [2*WORD_W-1:0]  w_shifted;
  logic                 early_exit;
  logic                 unused_b;

  // Only the low five bits of b carry a shift amount.
  assign unused_b = ^b[WORD_W-1:SHAMT_W];

  // Shift amount select and per-cycle step size.
  always_comb begin
    amt        = v ? b[SHAMT_W-1:0] : sa;
    step_n     = step_amt(count_q, STEP);
    count_next = count_q - step_n[SHAMT_W-1:0];
  end

  sll_step u_step (
    .w (w_q),
    .n (step_n),
    .y (w_shifted)
  );

`ifdef SLL_EARLY_EXIT_EN
  // Shifting zero any further cannot change the result.
  assign early_exit = (w_q == '0);
`else
  assign early_exit = 1'b0;
`endif

  // FSM, working register, remaining count and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            w_q        <= {{WORD_W{1'b0}}, a};
            count_q    <= amt;
            in_ready_q <= 1'b0;
            if (amt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (early_exit) begin
            count_q     <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            w_q     <= w_shifted;
            count_q <= count_next;
            if (count_next == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // in_ready stays low here so an accept never overlaps the result handshake.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The working register is frozen in DONE, so the result is stable under backpressure.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lo_out    = w_q[WORD_W-1:0];
  assign hi_out    = w_q[2*WORD_W-1:WORD_W];

endmodule

// File: tb/tb_sll_iter.sv
// Bench for sll_iter: two instances (STEP=1 and STEP=4) share all inputs and are
// checked against an arithmetic reference model of the shift and its latency.
module tb_sll_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        v;
  logic [4:0]  sa;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;

  logic        in_ready1, out_valid1;
  logic [31:0] lo1, hi1;
  logic        in_ready4, out_valid4;
  logic [31:0] lo4, hi4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sll_iter #(.STEP(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .v         (v),
    .sa        (sa),
    .a         (a),
    .b         (b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .lo_out    (lo1),
    .hi_out    (hi1)
  );

  sll_iter #(.STEP(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .v         (v),
    .sa        (sa),
    .a         (a),
    .b         (b),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .lo_out    (lo4),
    .hi_out    (hi4)
  );

  // Reference: the 64-bit product of shifting a left by amt, split into halves.
  function automatic void model(input logic [31:0] op, input int amt,
                                output logic [31:0] elo, output logic [31:0] ehi);
    elo = op << amt;
    ehi = (amt == 0) ? 32'h0 : (op >> (32 - amt));
  endfunction

  // Edges from the accept edge (inclusive) until out_valid is seen.
  function automatic int model_lat(input logic [31:0] op, input int amt, input int step);
    if (amt == 0) return 1;
`ifdef SLL_EARLY_EXIT_EN
    if (op == 32'h0) return 2;
`endif
    return (amt + step - 1) / step + 1;
  endfunction

  // Drive one op, scramble the operands after the accept edge, and record each
  // instance's latency and result. out_ready stays low so both hold in DONE.
  task automatic issue(input logic vi, input logic [4:0] sai, input logic [31:0] ai,
                       input logic [31:0] bi, output int l1, output int l4,
                       output logic [31:0] rlo1, output logic [31:0] rhi1,
                       output logic [31:0] rlo4, output logic [31:0] rhi4,
                       output logic rdy);
    l1 = 0; l4 = 0; rlo1 = '0; rhi1 = '0; rlo4 = '0; rhi4 = '0;
    @(negedge clk);
    rdy = in_ready1 & in_ready4;
    v = vi; sa = sai; a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    v = 1'($urandom); sa = 5'($urandom); a = $urandom; b = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (l1 == 0 && out_valid1) begin l1 = cyc; rlo1 = lo1; rhi1 = hi1; end
      if (l4 == 0 && out_valid4) begin l4 = cyc; rlo4 = lo4; rhi4 = hi4; end
      if (l1 != 0 && l4 != 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; v = 1'b0; sa = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL reset in_ready1: got %b want 1", in_ready1); end
    n_cmp++; if (in_ready4 !== 1'b1) begin n_bad++; $display("FAIL reset in_ready4: got %b want 1", in_ready4); end
    n_cmp++; if (out_valid1 !== 1'b0) begin n_bad++; $display("FAIL reset out_valid1: got %b want 0", out_valid1); end
    n_cmp++; if (out_valid4 !== 1'b0) begin n_bad++; $display("FAIL reset out_valid4: got %b want 0", out_valid4); end
    n_cmp++; if ({lo1, hi1} !== 64'h0) begin n_bad++; $display("FAIL reset out1: got %h want 0", {hi1, lo1}); end
    n_cmp++; if ({lo4, hi4} !== 64'h0) begin n_bad++; $display("FAIL reset out4: got %h want 0", {hi4, lo4}); end
  endtask

  task automatic test_directed(input string name, input logic vi, input logic [4:0] sai,
                               input logic [31:0] ai, input logic [31:0] bi,
                               input logic [31:0] elo, input logic [31:0] ehi,
                               input int el1, input int el4);
    int l1, l4;
    logic [31:0] rlo1, rhi1, rlo4, rhi4;
    logic rdy;
    issue(vi, sai, ai, bi, l1, l4, rlo1, rhi1, rlo4, rhi4, rdy);
    n_cmp++; if (l1 != el1) begin n_bad++; $display("FAIL %s lat1: got %0d want %0d", name, l1, el1); end
    n_cmp++; if (l4 != el4) begin n_bad++; $display("FAIL %s lat4: got %0d want %0d", name, l4, el4); end
    n_cmp++; if ({rhi1, rlo1} !== {ehi, elo}) begin n_bad++; $display("FAIL %s res1: got %h want %h", name, {rhi1, rlo1}, {ehi, elo}); end
    n_cmp++; if ({rhi4, rlo4} !== {ehi, elo}) begin n_bad++; $display("FAIL %s res4: got %h want %h", name, {rhi4, rlo4}, {ehi, elo}); end
    handshake();
  endtask

  task automatic test_backpressure();
    int l1, l4;
    logic [31:0] rlo1, rhi1, rlo4, rhi4, elo, ehi, ai;
    logic [4:0] amt;
    logic rdy;
    ai = $urandom | 32'h1; amt = 5'd13;
    model(ai, int'(amt), elo, ehi);
    issue(1'b1, 5'd2, ai, {27'h5a5a5a5, amt}, l1, l4, rlo1, rhi1, rlo4, rhi4, rdy);
    n_cmp++; if ({rhi1, rlo1} !== {ehi, elo}) begin n_bad++; $display("FAIL bp res1: got %h want %h", {rhi1, rlo1}, {ehi, elo}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; v = 1'b0; sa = 5'd3; a = ~ai;
      @(posedge clk); #1;
      n_cmp++; if ({out_valid1, out_valid4} !== 2'b11) begin n_bad++; $display("FAIL bp out_valid: got %b want 11", {out_valid1, out_valid4}); end
      n_cmp++; if ({in_ready1, in_ready4} !== 2'b00) begin n_bad++; $display("FAIL bp in_ready: got %b want 00", {in_ready1, in_ready4}); end
      n_cmp++; if ({hi1, lo1} !== {ehi, elo}) begin n_bad++; $display("FAIL bp hold1: got %h want %h", {hi1, lo1}, {ehi, elo}); end
      n_cmp++; if ({hi4, lo4} !== {ehi, elo}) begin n_bad++; $display("FAIL bp hold4: got %h want %h", {hi4, lo4}, {ehi, elo}); end
    end
    // in_valid is still high across the handshake edge; it must not be taken there.
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_cmp++; if ({in_ready1, in_ready4, out_valid1, out_valid4} !== 4'b1100) begin
      n_bad++; $display("FAIL bp after handshake: got %b want 1100", {in_ready1, in_ready4, out_valid1, out_valid4});
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int l1, l4;
    logic [31:0] rlo1, rhi1, rlo4, rhi4, elo, ehi, ai;
    logic rdy;
    @(negedge clk);
    v = 1'b0; sa = 5'd20; a = $urandom | 32'h100; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_cmp++; if ({in_ready1, in_ready4} !== 2'b11) begin n_bad++; $display("FAIL midrst in_ready: got %b want 11", {in_ready1, in_ready4}); end
    n_cmp++; if ({out_valid1, out_valid4} !== 2'b00) begin n_bad++; $display("FAIL midrst out_valid: got %b want 00", {out_valid1, out_valid4}); end
    n_cmp++; if ({hi1, lo1, hi4, lo4} !== 128'h0) begin n_bad++; $display("FAIL midrst outputs: got %h want 0", {hi1, lo1, hi4, lo4}); end
    @(negedge clk); rst_n = 1'b1;
    ai = $urandom;
    model(ai, 7, elo, ehi);
    issue(1'b0, 5'd7, ai, 32'h0, l1, l4, rlo1, rhi1, rlo4, rhi4, rdy);
    n_cmp++; if (l1 != model_lat(ai, 7, 1)) begin n_bad++; $display("FAIL midrst next lat1: got %0d want %0d", l1, model_lat(ai, 7, 1)); end
    n_cmp++; if (l4 != model_lat(ai, 7, 4)) begin n_bad++; $display("FAIL midrst next lat4: got %0d want %0d", l4, model_lat(ai, 7, 4)); end
    n_cmp++; if ({rhi4, rlo4} !== {ehi, elo}) begin n_bad++; $display("FAIL midrst next res4: got %h want %h", {rhi4, rlo4}, {ehi, elo}); end
    handshake();
  endtask

  task automatic test_zero_operand();
    int l1, l4;
    logic [31:0] rlo1, rhi1, rlo4, rhi4;
    logic rdy;
    issue(1'b0, 5'd20, 32'h0, 32'hffff_ffff, l1, l4, rlo1, rhi1, rlo4, rhi4, rdy);
    n_cmp++; if (l1 != model_lat(32'h0, 20, 1)) begin n_bad++; $display("FAIL zero lat1: got %0d want %0d", l1, model_lat(32'h0, 20, 1)); end
    n_cmp++; if (l4 != model_lat(32'h0, 20, 4)) begin n_bad++; $display("FAIL zero lat4: got %0d want %0d", l4, model_lat(32'h0, 20, 4)); end
    n_cmp++; if ({rhi1, rlo1, rhi4, rlo4} !== 128'h0) begin n_bad++; $display("FAIL zero res: got %h want 0", {rhi1, rlo1, rhi4, rlo4}); end
    handshake();
  endtask

  task automatic test_random(input int n_ops);
    int l1, l4, amt;
    logic [31:0] rlo1, rhi1, rlo4, rhi4, elo, ehi, ai, bi;
    logic [4:0] sai;
    logic vi, rdy;
    for (int k = 0; k < n_ops; k++) begin
      vi = 1'($urandom); sai = 5'($urandom); bi = $urandom;
      ai = (k % 7 == 3) ? 32'h0 : $urandom;
      amt = vi ? int'(bi[4:0]) : int'(sai);
      model(ai, amt, elo, ehi);
      issue(vi, sai, ai, bi, l1, l4, rlo1, rhi1, rlo4, rhi4, rdy);
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL rnd%0d ready before accept: got %b want 1", k, rdy); end
      n_cmp++; if (l1 != model_lat(ai, amt, 1)) begin n_bad++; $display("FAIL rnd%0d lat1 amt=%0d: got %0d want %0d", k, amt, l1, model_lat(ai, amt, 1)); end
      n_cmp++; if (l4 != model_lat(ai, amt, 4)) begin n_bad++; $display("FAIL rnd%0d lat4 amt=%0d: got %0d want %0d", k, amt, l4, model_lat(ai, amt, 4)); end
      n_cmp++; if ({rhi1, rlo1} !== {ehi, elo}) begin n_bad++; $display("FAIL rnd%0d res1 a=%h amt=%0d: got %h want %h", k, ai, amt, {rhi1, rlo1}, {ehi, elo}); end
      n_cmp++; if ({rhi4, rlo4} !== {ehi, elo}) begin n_bad++; $display("FAIL rnd%0d res4 a=%h amt=%0d: got %h want %h", k, ai, amt, {rhi4, rlo4}, {ehi, elo}); end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_directed("imm_sa4", 1'b0, 5'd4, 32'h8000_000f, 32'h0,
                  32'h0000_00f0, 32'h0000_0008, 5, 2);
    test_directed("var_amt0", 1'b1, 5'd9, 32'h1234_5678, 32'hffff_ffe0,
                  32'h1234_5678, 32'h0, 1, 1);
    test_directed("var_amt31", 1'b1, 5'd0, 32'hffff_ffff, 32'h0000_001f,
                  32'h8000_0000, 32'h7fff_ffff, 32, 9);
    test_backpressure();
    test_reset_mid_op();
    test_zero_operand();
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
